// File: rtl/nn_pkg.sv
// Shared types, widths and the activation helper for the single-neuron engine.
// No ports. Imported by nn_mac_unit and nn_neuron_engine.
package nn_pkg;

    localparam int unsigned N_PIX  = 9;   // pixels per 3x3 image
    localparam int unsigned PIX_W  = 8;   // unsigned pixel width
    localparam int unsigned WT_W   = 8;   // signed weight/bias width
    localparam int unsigned ACC_W  = 21;  // 9 products plus bias never overflow this
    localparam int unsigned PROD_W = 17;  // {0,pix} (9b signed) x weight (8b signed)
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned IMG_W  = N_PIX * PIX_W;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        ACT,
        DONE
    } state_t;

    // ReLU, arithmetic right shift, then clamp to the 8-bit unsigned output range.
    function automatic logic [PIX_W-1:0] sat_relu(input logic signed [ACC_W-1:0] acc,
                                                  input logic [3:0]              shift);
        logic signed [ACC_W-1:0] r;
        logic signed [ACC_W-1:0] max_out;
        max_out = ACC_W'(255);
        r       = acc >>> shift;
        if (acc[ACC_W-1]) begin
            return '0;
        end else if (r > max_out) begin
            return '1;
        end
        return r[PIX_W-1:0];
    endfunction

endpackage

// File: rtl/nn_mac_unit.sv
// Serial multiply-accumulate: unsigned pixel times signed weight, summed into a signed
// accumulator.
// Ports:
//   clk, rst  - clock and synchronous active-high reset (clears the accumulator)
//   load_i    - load accumulator with the sign-extended bias
//   en_i      - add the current pixel*weight product
//   pix_i     - unsigned pixel
//   wt_i      - signed weight
//   bias_i    - signed bias
//   acc_o     - signed running sum
module nn_mac_unit
    import nn_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_i,
    input  logic                    en_i,
    input  logic [PIX_W-1:0]        pix_i,
    input  logic signed [WT_W-1:0]  wt_i,
    input  logic signed [WT_W-1:0]  bias_i,
    output logic signed [ACC_W-1:0] acc_o
);

    logic signed [PROD_W-1:0] pix_ext;
    logic signed [PROD_W-1:0] wt_ext;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_q, acc_d;

    always_comb begin
        // Pixel is zero-extended so it stays positive in the signed multiply.
        pix_ext = {{(PROD_W - PIX_W){1'b0}}, pix_i};
        wt_ext  = {{(PROD_W - WT_W){wt_i[WT_W-1]}}, wt_i};
        prod    = pix_ext * wt_ext;
        acc_d   = acc_q;
        if (load_i) begin
            acc_d = {{(ACC_W - WT_W){bias_i[WT_W-1]}}, bias_i};
        end else if (en_i) begin
            acc_d = acc_q + {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/nn_neuron_engine.sv
// Single-neuron inference engine: latches a 3x3 8-bit image, runs 9 serial signed MACs on
// top of a bias, then applies ReLU, a fixed right shift and saturation to 8 bits.
// Ports:
//   clk, rst              - clock and synchronous active-high reset
//   in_valid/in_ready     - image handshake; InputImage sampled only on accept
//   InputImage            - pixel k at [8k+7:8k]
//   result/out_valid/out_ready - result handshake; result held until accepted
//   wt_we/wt_addr/wt_data - weight (addr 0..8) and bias (addr 9) writes, honoured in IDLE only
module nn_neuron_engine
    import nn_pkg::*;
#(
    parameter int unsigned SHIFT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IMG_W-1:0]  InputImage,
    output logic [PIX_W-1:0]  result,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              wt_we,
    input  logic [3:0]        wt_addr,
    input  logic [WT_W-1:0]   wt_data
);

    localparam logic [3:0] ShiftAmt = SHIFT[3:0];

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IMG_W-1:0]        img_q, img_d;
    logic signed [WT_W-1:0]  wt_q [N_PIX+1];
    logic signed [WT_W-1:0]  wt_d [N_PIX+1];
    logic [PIX_W-1:0]        result_q, result_d;
    logic                    out_valid_q, out_valid_d;

    logic                    mac_load;
    logic                    mac_en;
    logic [PIX_W-1:0]        pix_cur;
    logic signed [WT_W-1:0]  wt_cur;
    logic signed [ACC_W-1:0] acc;

    assign pix_cur = img_q[PIX_W*cnt_q +: PIX_W];
    assign wt_cur  = wt_q[cnt_q];

    nn_mac_unit u_mac (
        .clk    (clk),
        .rst    (rst),
        .load_i (mac_load),
        .en_i   (mac_en),
        .pix_i  (pix_cur),
        .wt_i   (wt_cur),
        .bias_i (wt_q[N_PIX]),
        .acc_o  (acc)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        img_d       = img_q;
        wt_d        = wt_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;
        mac_load    = 1'b0;
        mac_en      = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Weights only change between images so an image in flight sees one set.
                if (wt_we && (wt_addr <= 4'(N_PIX))) begin
                    wt_d[wt_addr] = wt_data;
                end
                if (in_valid) begin
                    img_d    = InputImage;
                    cnt_d    = '0;
                    mac_load = 1'b1;
                    state_d  = MAC;
                end
            end
            MAC: begin
                mac_en = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(N_PIX - 1)) begin
                    state_d = ACT;
                end
            end
            ACT: begin
                result_d    = sat_relu(acc, ShiftAmt);
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            img_q       <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i <= N_PIX; i++) begin
                wt_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            img_q       <= img_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            wt_q        <= wt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign result    = result_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_nn_neuron_engine.sv
// Self-checking bench for nn_neuron_engine: directed cases plus randomized images and
// weights, compared against an arithmetic model of the neuron.
module tb_nn_neuron_engine;

    localparam int unsigned TbShift = 4;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [71:0] InputImage;
    logic [7:0]  result;
    logic        out_valid;
    logic        out_ready;
    logic        wt_we;
    logic [3:0]  wt_addr;
    logic [7:0]  wt_data;

    nn_neuron_engine #(
        .SHIFT (TbShift)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .InputImage (InputImage),
        .result     (result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .wt_we      (wt_we),
        .wt_addr    (wt_addr),
        .wt_data    (wt_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model state: weights 0..8 and bias at index 9, plus the pixels of the next image.
    byte        mw [10];
    logic [7:0] px [9];

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model();
        int acc;
        acc = int'(mw[9]);
        for (int k = 0; k < 9; k++) begin
            acc += int'(px[k]) * int'(mw[k]);
        end
        if (acc < 0) return 0;
        acc = acc / (1 << TbShift);
        return (acc > 255) ? 255 : acc;
    endfunction

    task automatic write_wt(input int a, input int d);
        wt_we   = 1'b1;
        wt_addr = 4'(a);
        wt_data = 8'(d);
        tick();
        wt_we = 1'b0;
        if (a < 10) mw[a] = byte'(d);
    endtask

    task automatic set_all(input int w, input int bias, input int pix);
        for (int k = 0; k < 9; k++) write_wt(k, w);
        write_wt(9, bias);
        for (int k = 0; k < 9; k++) px[k] = 8'(pix);
    endtask

    // Present px, check latency, result, hold behaviour under backpressure and release.
    // With poke set, a weight write is attempted while the engine is busy.
    task automatic run_image(input int hold, input bit poke);
        int          lat;
        int          exp_r;
        logic [71:0] img;
        exp_r = model();
        for (int k = 0; k < 9; k++) img[k*8 +: 8] = px[k];
        InputImage = img;
        in_valid   = 1'b1;
        out_ready  = 1'b0;
        check("in_ready_idle", int'(in_ready), 1);
        tick();
        in_valid   = 1'b0;
        InputImage = {$urandom, $urandom, $urandom};
        if (poke) begin
            wt_we   = 1'b1;
            wt_addr = 4'd0;
            wt_data = 8'd5;
        end
        lat = 0;
        while (out_valid !== 1'b1 && lat < 30) begin
            tick();
            lat++;
        end
        wt_we = 1'b0;
        check("latency", lat, 10);
        check("result", int'(result), exp_r);
        check("in_ready_busy", int'(in_ready), 0);
        for (int i = 0; i < hold; i++) begin
            in_valid   = 1'b1;
            InputImage = {$urandom, $urandom, $urandom};
            tick();
            check("hold_valid", int'(out_valid), 1);
            check("hold_result", int'(result), exp_r);
            check("hold_in_ready", int'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("release_valid", int'(out_valid), 0);
        check("release_in_ready", int'(in_ready), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        InputImage = '0;
        out_ready  = 1'b0;
        wt_we      = 1'b0;
        wt_addr    = '0;
        wt_data    = '0;
        for (int k = 0; k < 10; k++) mw[k] = 0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_in_ready", int'(in_ready), 1);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_result", int'(result), 0);

        // Unit weights, pixels 10.
        set_all(1, 0, 10);
        run_image(0, 1'b0);

        // Large positive sum saturates.
        set_all(127, 127, 255);
        run_image(0, 1'b0);
        check("saturate_const", int'(result), 255);

        // Negative sum clamps to zero.
        set_all(-1, 0, 50);
        run_image(0, 1'b0);

        // Backpressure, then a second image after the handshake.
        set_all(1, 0, 10);
        run_image(5, 1'b0);
        for (int k = 0; k < 9; k++) px[k] = 8'd20;
        run_image(2, 1'b0);

        // Weight write while busy is dropped; in IDLE it applies to the next image.
        for (int k = 0; k < 9; k++) px[k] = 8'd10;
        run_image(1, 1'b1);
        write_wt(0, 5);
        run_image(0, 1'b0);

        // Out-of-range addresses leave the weight file alone.
        write_wt(12, 8'h80);
        write_wt(15, 8'h7F);
        run_image(0, 1'b0);

        // Reset in the middle of MAC discards the image and clears the weights.
        set_all(3, 20, 77);
        for (int k = 0; k < 9; k++) InputImage[k*8 +: 8] = px[k];
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) mw[k] = 0;
        check("midrst_in_ready", int'(in_ready), 1);
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_result", int'(result), 0);
        run_image(0, 1'b0);

        // Randomized weights, bias and pixels.
        for (int t = 0; t < 30; t++) begin
            for (int k = 0; k < 10; k++) write_wt(k, int'($urandom_range(0, 255)));
            write_wt(10 + int'($urandom_range(0, 5)), int'($urandom_range(0, 255)));
            for (int k = 0; k < 9; k++) px[k] = 8'($urandom_range(0, 255));
            run_image(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
